demux_frame_serializer: RTL and testbench
=========================================

# demux_frame_serializer

Upstream driver for the 1:8 demultiplexer (`in`, `sel[2:0]` → `y[7:0]`). It accepts parallel frames over a valid/ready handshake. Each frame carries a 3-bit channel address and a DATA_W-bit payload. The block holds `sel` at the frame's address while shifting the payload MSB-first onto the serial `in` line, one bit per clock, then inserts idle guard cycles. The downstream demux therefore sees a clean, glitch-free serial stream on exactly one output lane per frame.

## Interface
- DATA_W, 8: payload width in bits, 1..32.
- GAP_CYCLES, 1: guard cycles after each payload with `demux_in`=0 and `demux_sel` held, 0..15.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset.
- s_valid  input  1  frame offered.
- s_addr  input  3  destination channel, 0..7.
- s_data  input  DATA_W  payload.
- s_ready  output  1  block can accept a frame.
- demux_in  output  1  serial bit to the demux `in`.
- demux_sel  output  3  to the demux `sel`.
- bit_valid  output  1  `demux_in` carries a payload bit this cycle.
- frame_done  output  1  one-cycle pulse when a frame completes.
- busy  output  1  high in any state other than IDLE.

## Operation
- Reset: synchronous and active-low. On any rising edge with rst_n=0:
  - state ← IDLE, bit counter ← 0, gap counter ← 0.
  - demux_in ← 0, demux_sel ← 0, bit_valid ← 0, frame_done ← 0.
  - s_ready = 0 while rst_n=0.
  - busy = 0 while rst_n=0.
- s_ready = rst_n && (state==IDLE). It is combinational from the registered state and does not depend on s_valid.
- Accept: a frame is accepted at a rising edge with s_valid && s_ready. s_addr and s_data are captured into internal registers at that edge. Later changes on the inputs have no effect on the frame in flight.
- States:
  - IDLE: demux_in=0, bit_valid=0, demux_sel holds its last value. On accept, go to SHIFT with bit counter=DATA_W-1.
  - SHIFT: demux_sel=captured addr, demux_in=data[bit counter], bit_valid=1. The counter decrements each cycle. When the counter is 0, the next state is GAP if GAP_CYCLES>0, otherwise IDLE.
  - GAP: demux_in=0, bit_valid=0, demux_sel held. The state lasts exactly GAP_CYCLES cycles, then returns to IDLE.
- frame_done: a registered pulse, high for exactly the one cycle in which the state first reads IDLE after a completed frame.
- All of demux_in, demux_sel and bit_valid are registered outputs, with no combinational path from the s_* inputs.
- demux_sel never changes while bit_valid=1 or during GAP.
- s_valid held high in IDLE produces back-to-back frames. Each frame is separated by exactly one IDLE cycle in addition to the GAP cycles.
- If s_valid is asserted while busy: no accept, no side effects. The upstream must hold the frame until s_ready.
- Reset mid-frame: the frame is discarded, no frame_done is produced, and outputs take reset values at that edge.
- Out-of-range parameters are not supported.

## Timing
- Accept at edge k:
  - Payload bit DATA_W-1 appears on demux_in in cycle k+1.
  - Bit 0 appears in cycle k+DATA_W.
  - GAP occupies cycles k+DATA_W+1 .. k+DATA_W+GAP_CYCLES.
  - IDLE, with frame_done=1 and s_ready=1, in cycle k+DATA_W+GAP_CYCLES+1.
- Frame period with continuous s_valid: DATA_W+GAP_CYCLES+1 cycles. This is 10 cycles at the defaults.
- busy is high from cycle k+1 through the last GAP cycle.
- After rst_n deasserts, the first accept is possible at the next edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with s_valid=1. Required: s_ready=0, demux_in=0, demux_sel=0, bit_valid=0, frame_done=0 throughout, and no frame accepted.
- Single frame, defaults: addr=5, data=8'hA5, accepted at edge k. Required:
  - demux_sel=5 in cycles k+1..k+9.
  - demux_in=1,0,1,0,0,1,0,1 with bit_valid=1 in cycles k+1..k+8.
  - Cycle k+9: demux_in=0, bit_valid=0.
  - frame_done=1 only in cycle k+10.
  - Demux `y` shows activity on bit 5 only.
- Back-to-back: s_valid held high with addr=0/data=8'hFF, then addr=7/data=8'h01. Required: the second accept happens exactly 10 cycles after the first, and the lane switches 0→7 only in an IDLE cycle.
- Busy offer: assert s_valid with addr=3/data=8'h3C during SHIFT of a prior frame. Required: s_ready=0, no change to the running stream, and the frame is accepted in the first IDLE cycle.
- Reset mid-frame: assert rst_n=0 in cycle k+4 of a frame. Required: outputs are reset at that edge, no frame_done pulse, and a new frame after release is serialized correctly.
- GAP_CYCLES=0, DATA_W=4: data=4'b1001, addr=2. Required: bits 1,0,0,1 in cycles k+1..k+4, frame_done in cycle k+5, period 5 cycles.

Source files
------------

// File: rtl/demux_frame_serializer.sv
// demux_frame_serializer: valid/ready frames (s_addr,s_data) -> MSB-first serial demux_in on lane demux_sel, with bit_valid/frame_done/busy status
module demux_frame_serializer #(
  parameter int DATA_W = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [2:0]        s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              demux_in,
  output logic [2:0]        demux_sel,
  output logic              bit_valid,
  output logic              frame_done,
  output logic              busy
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2;
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W - 1);
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] addr_q, addr_d, sel_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic in_q, valid_q, done_q;
  assign s_ready = rst_n && state_q == IDLE;
  assign busy = rst_n && state_q != IDLE;
  assign demux_in = in_q;
  assign demux_sel = sel_q;
  assign bit_valid = valid_q;
  assign frame_done = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == IDLE && s_valid && s_ready) begin
      state_d = SHIFT;
      cnt_d = CNT_INIT;
      addr_d = s_addr;
      data_d = s_data;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      gap_d = cnt_q == '0 ? GAP_INIT : gap_q;
      state_d = cnt_q != '0 ? SHIFT : GAP_CYCLES > 0 ? GAP : IDLE;
    end else if (state_q == GAP) begin
      gap_d = gap_q == '0 ? '0 : gap_q - 1'b1;
      state_d = gap_q == '0 ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gap_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      in_q <= 1'b0;
      sel_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      addr_q <= addr_d;
      data_q <= data_d;
      in_q <= state_d == SHIFT && data_d[cnt_d];
      sel_q <= state_d == SHIFT ? addr_d : sel_q;
      valid_q <= state_d == SHIFT;
      done_q <= state_q != IDLE && state_d == IDLE;
    end
  end
endmodule

// File: tb/tb_demux_frame_serializer.sv
// tb_demux_frame_serializer: directed self-checking bench for default and DATA_W=4/GAP_CYCLES=0 builds
module tb_demux_frame_serializer;
  logic clk = 1'b0, rst_n, s_valid, s_ready, demux_in, bit_valid, frame_done, busy;
  logic [2:0] s_addr, demux_sel;
  logic [7:0] s_data;
  logic v1, r1, in1, bv1, fd1, busy1;
  logic [2:0] a1, sel1;
  logic [3:0] d1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  demux_frame_serializer u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data),
    .s_ready(s_ready), .demux_in(demux_in), .demux_sel(demux_sel), .bit_valid(bit_valid),
    .frame_done(frame_done), .busy(busy)
  );
  demux_frame_serializer #(.DATA_W(4), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(v1), .s_addr(a1), .s_data(d1),
    .s_ready(r1), .demux_in(in1), .demux_sel(sel1), .bit_valid(bv1),
    .frame_done(fd1), .busy(busy1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_addr = 3'd5; s_data = 8'hA5;
    v1 = 1'b1; a1 = 3'd2; d1 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({s_ready, demux_in, demux_sel, bit_valid, frame_done, busy} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b want 00000000", i, {s_ready, demux_in, demux_sel, bit_valid, frame_done, busy});
      end
      checks++;
      if ({r1, in1, sel1, bv1, fd1, busy1} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs_u1 cycle %0d got %b want 00000000", i, {r1, in1, sel1, bv1, fd1, busy1});
      end
    end
    s_valid = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, bit_valid, s_ready, busy1, r1} !== 5'b00101) begin
      errors++;
      $display("FAIL reset_no_accept got %b want 00101", {busy, bit_valid, s_ready, busy1, r1});
    end
  endtask
  task automatic test_single();
    logic [7:0] y_act;
    logic [7:0] exp_d;
    y_act = '0; exp_d = 8'hA5;
    s_valid = 1'b1; s_addr = 3'd5; s_data = 8'hA5;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", s_ready);
    end
    tick();
    s_valid = 1'b0; s_addr = 3'd0; s_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y_act |= 8'(demux_in) << demux_sel;
      checks++;
      if ({demux_in, bit_valid, demux_sel, frame_done} !== {exp_d[7-i], 1'b1, 3'd5, 1'b0}) begin
        errors++;
        $display("FAIL single_bit%0d got %b want %b", i, {demux_in, bit_valid, demux_sel, frame_done}, {exp_d[7-i], 1'b1, 3'd5, 1'b0});
      end
      tick();
    end
    checks++;
    if ({demux_in, bit_valid, demux_sel, frame_done, busy} !== 7'b0010101) begin
      errors++;
      $display("FAIL single_gap got %b want 0010101", {demux_in, bit_valid, demux_sel, frame_done, busy});
    end
    tick();
    checks++;
    if ({frame_done, s_ready, busy, bit_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL single_done got %b want 1100", {frame_done, s_ready, busy, bit_valid});
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got %b want 0", frame_done);
    end
    checks++;
    if (y_act !== 8'h20) begin
      errors++;
      $display("FAIL single_lane got %h want 20", y_act);
    end
  endtask
  task automatic test_back_to_back();
    int acc1, acc2, nb;
    logic [15:0] bits;
    logic bad_switch, prev_busy;
    logic [2:0] prev_sel;
    acc1 = -1; acc2 = -1; nb = 0; bits = '0; bad_switch = 1'b0;
    prev_busy = busy; prev_sel = demux_sel;
    s_valid = 1'b1; s_addr = 3'd0; s_data = 8'hFF;
    for (int c = 0; c < 30; c++) begin
      if (s_valid && s_ready) begin
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
      tick();
      if (acc1 == c) begin s_addr = 3'd7; s_data = 8'h01; end
      if (acc2 == c) s_valid = 1'b0;
      if (demux_sel !== prev_sel && prev_busy) bad_switch = 1'b1;
      if (bit_valid) begin bits = {bits[14:0], demux_in}; nb++; end
      prev_busy = busy; prev_sel = demux_sel;
    end
    checks++;
    if (acc2 - acc1 !== 10) begin
      errors++;
      $display("FAIL b2b_period got %0d want 10", acc2 - acc1);
    end
    checks++;
    if (nb !== 16 || bits !== 16'hFF01) begin
      errors++;
      $display("FAIL b2b_stream got %0d bits %h want 16 bits ff01", nb, bits);
    end
    checks++;
    if (bad_switch !== 1'b0 || demux_sel !== 3'd7) begin
      errors++;
      $display("FAIL b2b_lane got bad_switch=%b sel=%0d want 0 and 7", bad_switch, demux_sel);
    end
  endtask
  task automatic test_busy_offer();
    int acc;
    logic [15:0] bits;
    logic [15:0] sels_ok;
    logic ready_bad;
    int nb;
    acc = -1; bits = '0; sels_ok = '0; ready_bad = 1'b0; nb = 0;
    s_valid = 1'b1; s_addr = 3'd1; s_data = 8'hC3;
    tick();
    s_valid = 1'b0;
    for (int c = 1; c < 26; c++) begin
      if (c == 3) begin s_valid = 1'b1; s_addr = 3'd3; s_data = 8'h3C; end
      if (bit_valid && nb < 16) begin
        bits = {bits[14:0], demux_in};
        sels_ok = {sels_ok[14:0], demux_sel == (nb < 8 ? 3'd1 : 3'd3)};
        nb++;
      end
      if (c >= 3 && c <= 9 && s_ready) ready_bad = 1'b1;
      if (s_valid && s_ready) begin
        acc = c;
        tick();
        s_valid = 1'b0; s_data = 8'h00;
      end else tick();
    end
    checks++;
    if (acc !== 10) begin
      errors++;
      $display("FAIL busy_accept_cycle got %0d want 10", acc);
    end
    checks++;
    if (ready_bad !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b want 0", ready_bad);
    end
    checks++;
    if (bits !== 16'hC33C || sels_ok !== 16'hFFFF) begin
      errors++;
      $display("FAIL busy_stream got %h sel_ok %h want c33c ffff", bits, sels_ok);
    end
  endtask
  task automatic test_reset_mid();
    logic done_seen;
    logic [7:0] bits;
    logic sel_bad;
    done_seen = 1'b0; bits = '0; sel_bad = 1'b0;
    s_valid = 1'b1; s_addr = 3'd6; s_data = 8'hF0;
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({s_ready, demux_in, demux_sel, bit_valid, frame_done, busy} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 00000000", {s_ready, demux_in, demux_sel, bit_valid, frame_done, busy});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (frame_done || busy) done_seen = 1'b1;
      tick();
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done got %b want 0", done_seen);
    end
    s_valid = 1'b1; s_addr = 3'd4; s_data = 8'h69;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits = {bits[6:0], demux_in & bit_valid};
      if (demux_sel !== 3'd4 || !bit_valid) sel_bad = 1'b1;
      tick();
    end
    checks++;
    if (bits !== 8'h69 || sel_bad !== 1'b0) begin
      errors++;
      $display("FAIL midreset_new_frame got %h sel_bad=%b want 69 0", bits, sel_bad);
    end
    repeat (3) tick();
  endtask
  task automatic test_gap0();
    int acc1, acc2;
    logic [3:0] bits;
    logic [4:0] fds, bvs;
    acc1 = -1; acc2 = -1; bits = '0; fds = '0; bvs = '0;
    v1 = 1'b1; a1 = 3'd2; d1 = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      if (v1 && r1) begin
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
      tick();
      if (acc2 >= 0) v1 = 1'b0;
      if (acc1 >= 0 && c - acc1 + 1 >= 1 && c - acc1 + 1 <= 5) begin
        if (c - acc1 + 1 <= 4) bits = {bits[2:0], in1};
        fds = {fds[3:0], fd1};
        bvs = {bvs[3:0], bv1 && sel1 == 3'd2};
      end
    end
    checks++;
    if (bits !== 4'b1001 || bvs !== 5'b11110) begin
      errors++;
      $display("FAIL gap0_bits got %b valid %b want 1001 11110", bits, bvs);
    end
    checks++;
    if (fds !== 5'b00001) begin
      errors++;
      $display("FAIL gap0_done got %b want 00001", fds);
    end
    checks++;
    if (acc2 - acc1 !== 5) begin
      errors++;
      $display("FAIL gap0_period got %0d want 5", acc2 - acc1);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_offer();
    test_reset_mid();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
